// File: rtl/signed_arith_pkg.sv
// Shared signed-arithmetic definitions: divider FSM encoding and two's-complement helpers
// used by the divider RTL and the multiplier bench.
package signed_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Caller sign-extends narrower operands to 32 bits before calling.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

endpackage

// File: rtl/signed_divider_if.sv
// Request/result handshake bundle for the sequential signed divider.
interface signed_divider_if #(
  parameter int M = 5,
  parameter int N = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/signed_divider_step.sv
// One restoring division iteration on magnitudes: shift {rem,quo} left, trial-subtract |B|.
module signed_divider_step #(
  parameter int M = 5,
  parameter int N = 3
) (
  input  logic [N:0]   rem_in,
  input  logic [M-1:0] quo_in,
  input  logic [N-1:0] mag_b,
  output logic [N:0]   rem_out,
  output logic [M-1:0] quo_out
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  always_comb begin
    shifted = {rem_in, quo_in[M-1]};
    trial   = shifted - {2'b00, mag_b};
    if (!trial[N+1]) begin
      rem_out = trial[N:0];
      quo_out = {quo_in[M-2:0], 1'b1};
    end else begin
      rem_out = shifted[N:0];
      quo_out = {quo_in[M-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Sequential signed divider: magnitudes divided by restoring steps, signs applied at the end.
//   state | meaning
//   IDLE  | ready for a request; accept captures magnitudes, signs and div0/ovf
//   CALC  | one restoring step per cycle, M cycles
//   FIX   | apply signs / special cases, register the result
//   DONE  | result valid, held until consumer accepts
module signed_divider
  import signed_arith_pkg::*;
#(
  parameter int M = 5,
  parameter int N = 3
) (
  input  logic clk,
  input  logic rst_n,
  signed_divider_if.slave bus
);

  localparam int CW = $clog2(M + 1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [M-1:0]  quo;
  logic [N:0]    rem;
  logic [N-1:0]  mag_b;
  logic [N-1:0]  a_low;
  logic          sa, sb, dz, ov;

  logic [M-1:0]  abs_a;
  logic [N-1:0]  abs_b;
  logic          req_dz, req_ov;
  logic [N:0]    rem_nxt;
  logic [M-1:0]  quo_nxt;

  assign abs_a  = M'(abs32(32'(signed'(bus.dividend))));
  assign abs_b  = N'(abs32(32'(signed'(bus.divisor))));
  assign req_dz = (bus.divisor == '0);
  assign req_ov = (bus.dividend == {1'b1, {(M-1){1'b0}}}) && (bus.divisor == '1);

  signed_divider_step #(.M(M), .N(N)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .mag_b   (mag_b),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      mag_b         <= '0;
      a_low         <= '0;
      sa            <= 1'b0;
      sb            <= 1'b0;
      dz            <= 1'b0;
      ov            <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.div_zero  <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            quo          <= abs_a;
            rem          <= '0;
            mag_b        <= abs_b;
            a_low        <= bus.dividend[N-1:0];
            sa           <= bus.dividend[M-1];
            sb           <= bus.divisor[N-1];
            dz           <= req_dz;
            ov           <= req_ov;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.overflow <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(M - 1)) state <= FIX;
        end
        FIX: begin
          // Special cases override the iterated result; the datapath still ran so latency is fixed.
          if (dz) begin
            bus.quotient  <= '1;
            bus.remainder <= a_low;
          end else if (ov) begin
            bus.quotient  <= {1'b1, {(M-1){1'b0}}};
            bus.remainder <= '0;
          end else begin
            bus.quotient  <= (sa ^ sb) ? M'(neg32(32'(quo))) : quo;
            bus.remainder <= sa ? N'(neg32(32'(rem))) : rem[N-1:0];
          end
          bus.div_zero  <= dz;
          bus.overflow  <= ov;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
